// File: rtl/edge_detect_pkg.sv
// Shared types and constants for the multi-channel edge detector.
// Optional build macro used by the channel logic: EDGE_SYNC_EN.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int SYNC_STAGES = 2;

  // True when a filtered transition to new_lvl is an event under mode m.
  function automatic logic mode_match(input edge_mode_t m, input logic new_lvl);
    logic hit;
    hit = 1'b0;
    unique case (m)
      EDGE_RISE: hit = new_lvl;
      EDGE_FALL: hit = ~new_lvl;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One channel: optional input synchronizer, glitch filter, edge pulse and sticky flag.
// Build macro EDGE_SYNC_EN inserts a 2-flop synchronizer ahead of the filter.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int FILT_CYC = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_raw,
  input  edge_mode_t mode,
  input  logic       clr,
  output logic       out_edge,
  output logic       out_level,
  output logic       out_flag
);

  localparam int CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_CYC - 1);

  logic          s;
  logic [CW-1:0] cnt;
  logic          upd;
  logic          hit;

`ifdef EDGE_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
`else
  assign s = in_raw;
`endif

  // The new level is accepted on the FILT_CYC-th consecutive differing sample.
  assign upd = (s != out_level) && (cnt == LAST);

  always_comb begin
    hit = 1'b0;
    if (upd) begin
      hit = mode_match(mode, s);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      out_level <= 1'b0;
      out_edge  <= 1'b0;
    end else begin
      out_edge <= hit;
      if (s == out_level) begin
        cnt <= '0;
      end else if (upd) begin
        cnt       <= '0;
        out_level <= s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Flag follows the registered pulse, so a clear seen alongside the pulse loses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_flag <= 1'b0;
    end else if (out_edge) begin
      out_flag <= 1'b1;
    end else if (clr) begin
      out_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/edge_detect_multi.sv
// N_CH independent filtered edge detectors with per-channel mode and a global any-event output.
// Build macro EDGE_SYNC_EN adds a 2-flop input synchronizer in every channel.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int FILT_CYC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   in_edge,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   out_edge,
  output logic [N_CH-1:0]   out_level,
  output logic [N_CH-1:0]   out_flag,
  output logic              out_any
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    edge_detect_chan #(
      .FILT_CYC (FILT_CYC)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .in_raw    (in_edge[i]),
      .mode      (edge_mode_t'(mode[2*i +: 2])),
      .clr       (clr[i]),
      .out_edge  (out_edge[i]),
      .out_level (out_level[i]),
      .out_flag  (out_flag[i])
    );
  end

  assign out_any = |out_edge;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi (N_CH=4, FILT_CYC=3): vector table plus hand sequences.
module tb_edge_detect_multi;

  localparam int N_CH = 4;
  localparam int W    = 3 * N_CH + 1;

  logic              clk;
  logic              reset;
  logic [N_CH-1:0]   in_edge;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   out_edge;
  logic [N_CH-1:0]   out_level;
  logic [N_CH-1:0]   out_flag;
  logic              out_any;

  edge_detect_multi #(
    .N_CH     (N_CH),
    .FILT_CYC (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_edge   (in_edge),
    .mode      (mode),
    .clr       (clr),
    .out_edge  (out_edge),
    .out_level (out_level),
    .out_flag  (out_flag),
    .out_any   (out_any)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] in_v;
    logic [7:0] mode_v;
    logic [3:0] clr_v;
    logic [3:0] e_edge;
    logic [3:0] e_level;
    logic [3:0] e_flag;
  } vec_t;

  vec_t tbl[64];
  int   n_vec = 0;

  function automatic void add(input logic [3:0] in_v, input logic [7:0] mode_v,
                              input logic [3:0] clr_v, input logic [3:0] e_edge,
                              input logic [3:0] e_level, input logic [3:0] e_flag);
    tbl[n_vec] = '{in_v, mode_v, clr_v, e_edge, e_level, e_flag};
    n_vec++;
  endfunction

  function automatic logic [W-1:0] pack_exp(input logic [3:0] e_edge, input logic [3:0] e_level,
                                            input logic [3:0] e_flag);
    return {|e_edge, e_flag, e_level, e_edge};
  endfunction

  task automatic check_pop(input string name);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    got = {out_any, out_flag, out_level, out_edge};
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got any/flag/level/edge=%b", name, got);
    end else begin
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL %s: got any/flag/level/edge=%b expected %b", name, got, exp);
      end
    end
  endtask

  // driver: apply one cycle of inputs, expect outputs after the next rising edge
  task automatic step(input string name, input logic [3:0] in_v, input logic [7:0] mode_v,
                      input logic [3:0] clr_v, input logic [3:0] e_edge,
                      input logic [3:0] e_level, input logic [3:0] e_flag);
    in_edge = in_v;
    mode    = mode_v;
    clr     = clr_v;
    exp_q.push_back(pack_exp(e_edge, e_level, e_flag));
    @(posedge clk);
    #1;
    check_pop(name);
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      step($sformatf("vec%0d", i), tbl[i].in_v, tbl[i].mode_v, tbl[i].clr_v,
           tbl[i].e_edge, tbl[i].e_level, tbl[i].e_flag);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    in_edge = '0;
    mode    = '0;
    clr     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    in_edge = '0;
    mode    = '0;
    clr     = '0;
    #2;
    do_reset();
    exp_q.push_back('0);
    check_pop("reset_state");

`ifdef EDGE_SYNC_EN
    // Synchronizer adds two cycles: pulse on the 5th edge after the change.
    step("sync_idle", 4'b0000, 8'h01, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("sync_wait%0d", i), 4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    step("sync_pulse", 4'b0001, 8'h01, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    step("sync_flag",  4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    step("sync_steady", 4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    step("sync_clr", 4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
`else
    // ch0 RISE: pulse at 3rd edge, sticky flag until clr
    add(4'b0000, 8'h01, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 8'h01, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    add(4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    add(4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    add(4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    // ch1 BOTH glitches of 2 samples, restarted by a matching sample
    add(4'b0011, 8'h0D, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0011, 8'h0D, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0001, 8'h0D, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0011, 8'h0D, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0011, 8'h0D, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0001, 8'h0D, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0001, 8'h0D, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0001, 8'h0D, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    // modes OFF/RISE/FALL/BOTH on ch0..ch3, all inputs 0->1->0
    add(4'b0000, 8'hE4, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1111, 8'hE4, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1111, 8'hE4, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1111, 8'hE4, 4'b0000, 4'b1010, 4'b1111, 4'b0000);
    add(4'b1111, 8'hE4, 4'b0000, 4'b0000, 4'b1111, 4'b1010);
    add(4'b1111, 8'hE4, 4'b0000, 4'b0000, 4'b1111, 4'b1010);
    add(4'b0000, 8'hE4, 4'b0000, 4'b0000, 4'b1111, 4'b1010);
    add(4'b0000, 8'hE4, 4'b0000, 4'b0000, 4'b1111, 4'b1010);
    add(4'b0000, 8'hE4, 4'b0000, 4'b1100, 4'b0000, 4'b1010);
    add(4'b0000, 8'hE4, 4'b0000, 4'b0000, 4'b0000, 4'b1110);
    add(4'b0000, 8'hE4, 4'b0000, 4'b0000, 4'b0000, 4'b1110);
    add(4'b0000, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 4'b1110);
    // ch3 set/clear race: clr in the pulse cycle loses, later clr wins
    add(4'b0000, 8'hE4, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1000, 8'hE4, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1000, 8'hE4, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1000, 8'hE4, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    add(4'b1000, 8'hE4, 4'b1000, 4'b0000, 4'b1000, 4'b1000);
    add(4'b1000, 8'hE4, 4'b1000, 4'b0000, 4'b1000, 4'b0000);
    add(4'b1000, 8'hE4, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    // ch0 RISE count in progress (cnt reaches 2) before an async reset
    add(4'b1001, 8'hE5, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    add(4'b1001, 8'hE5, 4'b0000, 4'b0000, 4'b1000, 4'b0000);

    run_vectors(0, 17);
    do_reset();
    run_vectors(17, n_vec);

    // async reset mid-count, observed before any further clock edge
    in_edge = 4'b1001;
    mode    = 8'hE5;
    clr     = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back('0);
    check_pop("async_reset_now");
    @(negedge clk);
    exp_q.push_back('0);
    check_pop("reset_held");
    reset = 1'b0;
    // inputs held high through release: ch0 RISE and ch3 BOTH pulse on the 3rd edge
    step("rel1", 4'b1001, 8'hE5, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step("rel2", 4'b1001, 8'hE5, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step("rel3", 4'b1001, 8'hE5, 4'b0000, 4'b1001, 4'b1001, 4'b0000);
    step("rel4", 4'b1001, 8'hE5, 4'b0000, 4'b0000, 4'b1001, 4'b1001);
    step("rel5", 4'b1001, 8'hE5, 4'b0000, 4'b0000, 4'b1001, 4'b1001);
`endif

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
